// File: rtl/mp_mul_seq.sv
// mp_mul_seq: sequencer for a schoolbook multi-precision multiply.
// Walks rows i = 0..N-1 of A*B[i]. For each row it streams N limb ops
// into the mul_acc core and writes the returned words into the R scratchpad.
// It then stores the row's final carry at R[i+N].
// A tag shift register tracks each op through the MAC latency. Its tail is
// aligned with mac_out and decides the write and the MAC carry controls.
// MAC_LAT must be at least 2.

module mp_mul_seq #(
    parameter int CP_D_WIDTH = 72,
    parameter int N_W        = 4,
    parameter int ADDR_W     = 5,
    parameter int MAC_LAT    = 6
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [N_W-1:0]        n_limbs,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     a_addr,
    output logic [ADDR_W-1:0]     b_addr,
    input  logic [CP_D_WIDTH-1:0] a_data,
    input  logic [CP_D_WIDTH-1:0] b_data,
    output logic [ADDR_W-1:0]     r_raddr,
    input  logic [CP_D_WIDTH-1:0] r_rdata,
    output logic                  r_we,
    output logic [ADDR_W-1:0]     r_waddr,
    output logic [CP_D_WIDTH-1:0] r_wdata,
    output logic                  mac_en,
    output logic                  mac_arith_op,
    output logic                  mac_reg_op,
    output logic [CP_D_WIDTH-1:0] mac_a,
    output logic [CP_D_WIDTH-1:0] mac_b,
    output logic [CP_D_WIDTH-1:0] mac_c,
    input  logic [CP_D_WIDTH-1:0] mac_out,
    input  logic [CP_D_WIDTH-1:0] mac_carry
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CARRY = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                        state_q;
    logic [N_W-1:0]                n_q;
    logic [N_W-1:0]                i_q;
    logic [N_W-1:0]                j_q;

    // Operand stage: describes the op whose read data is arriving this cycle.
    logic                          op_vld_q;
    logic                          op_first_q;
    logic                          op_row0_q;
    logic [ADDR_W-1:0]             op_addr_q;

    // Tag pipeline; index MAC_LAT-1 lines up with mac_out.
    logic [MAC_LAT-1:0]            tag_vld_q;
    logic [MAC_LAT-1:0]            tag_first_q;
    logic [MAC_LAT-1:0][ADDR_W-1:0] tag_addr_q;

    logic                          issue_s;
    logic [N_W-1:0]                n_last_s;
    logic [ADDR_W-1:0]             sum_addr_s;
    logic [ADDR_W-1:0]             carry_addr_s;
    logic                          drain_done_s;
    logic                          tag_out_vld_s;

    assign issue_s       = (state_q == ST_ISSUE);
    assign n_last_s      = n_q - N_W'(1);
    assign sum_addr_s    = ADDR_W'(i_q) + ADDR_W'(j_q);
    assign carry_addr_s  = ADDR_W'(i_q) + ADDR_W'(n_q);
    assign tag_out_vld_s = tag_vld_q[MAC_LAT-1];

    // The row's last result is at the tail when nothing valid is behind it.
    assign drain_done_s  = tag_out_vld_s && !op_vld_q &&
                           (tag_vld_q[MAC_LAT-2:0] == {(MAC_LAT-1){1'b0}});

    // Status and read ports are decoded straight from the state registers.
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    // An empty run has nothing to compute, so the MAC is never enabled for it.
    assign mac_en  = busy && (n_q != {N_W{1'b0}});
    assign a_addr  = issue_s ? ADDR_W'(j_q) : {ADDR_W{1'b0}};
    assign b_addr  = issue_s ? ADDR_W'(i_q) : {ADDR_W{1'b0}};
    assign r_raddr = issue_s ? sum_addr_s   : {ADDR_W{1'b0}};

    // Row/column sequencing FSM.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            n_q     <= {N_W{1'b0}};
            i_q     <= {N_W{1'b0}};
            j_q     <= {N_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        n_q     <= n_limbs;
                        i_q     <= {N_W{1'b0}};
                        j_q     <= {N_W{1'b0}};
                        state_q <= (n_limbs == {N_W{1'b0}}) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (j_q == n_last_s) begin
                        j_q     <= {N_W{1'b0}};
                        state_q <= ST_DRAIN;
                    end else begin
                        j_q     <= j_q + N_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        state_q <= ST_CARRY;
                    end
                end
                ST_CARRY: begin
                    if (i_q == n_last_s) begin
                        state_q <= ST_DONE;
                    end else begin
                        i_q     <= i_q + N_W'(1);
                        state_q <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand-stage tag and MAC-latency tag shift register.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            op_vld_q    <= 1'b0;
            op_first_q  <= 1'b0;
            op_row0_q   <= 1'b0;
            op_addr_q   <= {ADDR_W{1'b0}};
            tag_vld_q   <= {MAC_LAT{1'b0}};
            tag_first_q <= {MAC_LAT{1'b0}};
            tag_addr_q  <= {(MAC_LAT*ADDR_W){1'b0}};
        end else begin
            op_vld_q    <= issue_s;
            op_first_q  <= issue_s && (j_q == {N_W{1'b0}});
            op_row0_q   <= issue_s && (i_q == {N_W{1'b0}});
            op_addr_q   <= issue_s ? sum_addr_s : {ADDR_W{1'b0}};
            tag_vld_q   <= {tag_vld_q[MAC_LAT-2:0], op_vld_q};
            tag_first_q <= {tag_first_q[MAC_LAT-2:0], op_first_q};
            tag_addr_q  <= {tag_addr_q[MAC_LAT-2:0], op_addr_q};
        end
    end

    // Operands to the MAC; row 0 ignores the scratchpad so R needs no clear.
    always_comb begin
        mac_a = {CP_D_WIDTH{1'b0}};
        mac_b = {CP_D_WIDTH{1'b0}};
        mac_c = {CP_D_WIDTH{1'b0}};
        if (op_vld_q) begin
            mac_a = a_data;
            mac_b = b_data;
            mac_c = op_row0_q ? {CP_D_WIDTH{1'b0}} : r_rdata;
        end else begin
            mac_c = {CP_D_WIDTH{1'b0}};
        end
    end

    // Result write-back and MAC carry control from the tail tag.
    always_comb begin
        r_we         = 1'b0;
        r_waddr      = {ADDR_W{1'b0}};
        r_wdata      = {CP_D_WIDTH{1'b0}};
        mac_arith_op = 1'b0;
        mac_reg_op   = 1'b0;
        if (tag_out_vld_s) begin
            r_we         = 1'b1;
            r_waddr      = tag_addr_q[MAC_LAT-1];
            r_wdata      = mac_out;
            mac_arith_op = !tag_first_q[MAC_LAT-1];
            mac_reg_op   = 1'b0;
        end else if (state_q == ST_CARRY) begin
            r_we         = 1'b1;
            r_waddr      = carry_addr_s;
            r_wdata      = mac_carry;
            mac_reg_op   = 1'b1;
        end else begin
            mac_reg_op   = busy;
        end
    end

endmodule

// File: tb/tb_mp_mul_seq.sv
// Bench for mp_mul_seq: mul_acc behavioural model, 1-cycle A/B/R memories,
// table vectors, random N=3 products against a big-integer reference, and
// hand-written restart/reset sequences.
`timescale 1ns/1ps
module tb_mp_mul_seq;

    localparam int W      = 72;
    localparam int N_W    = 4;
    localparam int ADDR_W = 5;
    localparam int L      = 6;
    localparam int MAXN   = 4;
    localparam int BW     = MAXN * W;
    localparam int PW     = 2 * BW;

    logic              clock = 1'b0;
    logic              nreset;
    logic              start;
    logic [N_W-1:0]    n_limbs;
    logic              busy, done;
    logic [ADDR_W-1:0] a_addr, b_addr, r_raddr, r_waddr;
    logic [W-1:0]      a_data, b_data, r_rdata, r_wdata;
    logic              r_we, mac_en, mac_arith_op, mac_reg_op;
    logic [W-1:0]      mac_a, mac_b, mac_c, mac_out, mac_carry;

    int n_checks = 0;
    int n_fail   = 0;

    mp_mul_seq #(.CP_D_WIDTH(W), .N_W(N_W), .ADDR_W(ADDR_W), .MAC_LAT(L)) dut (
        .clock(clock), .nreset(nreset), .start(start), .n_limbs(n_limbs),
        .busy(busy), .done(done), .a_addr(a_addr), .b_addr(b_addr),
        .a_data(a_data), .b_data(b_data), .r_raddr(r_raddr), .r_rdata(r_rdata),
        .r_we(r_we), .r_waddr(r_waddr), .r_wdata(r_wdata), .mac_en(mac_en),
        .mac_arith_op(mac_arith_op), .mac_reg_op(mac_reg_op),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_out(mac_out), .mac_carry(mac_carry)
    );

    always #5 clock = ~clock;

    // Memories with one cycle of read latency.
    logic [W-1:0] mem_a [0:31];
    logic [W-1:0] mem_b [0:31];
    logic [W-1:0] mem_r [0:31];
    logic [W-1:0] fill_r [0:31];
    logic         fill_req;

    always @(posedge clock) begin
        a_data  <= mem_a[a_addr];
        b_data  <= mem_b[b_addr];
        r_rdata <= mem_r[r_raddr];
        if (fill_req) begin
            for (int k = 0; k < 32; k++) mem_r[k] <= fill_r[k];
        end else if (r_we) begin
            mem_r[r_waddr] <= r_wdata;
        end
    end

    // mul_acc model: A*B+C delayed L enabled cycles, carry-in chosen at the output.
    logic [2*W-1:0] pipe_m [0:L-1];
    logic [W-1:0]   carry_m;
    logic [2*W-1:0] sum_m;

    always_comb sum_m = pipe_m[L-1] + (mac_arith_op ? {{W{1'b0}}, carry_m} : {(2*W){1'b0}});
    assign mac_out   = sum_m[W-1:0];
    assign mac_carry = carry_m;

    always @(posedge clock) begin
        if (mac_en) begin
            pipe_m[0] <= {{W{1'b0}}, mac_a} * {{W{1'b0}}, mac_b} + {{W{1'b0}}, mac_c};
            for (int k = 1; k < L; k++) pipe_m[k] <= pipe_m[k-1];
            if (!mac_reg_op) carry_m <= sum_m[2*W-1:W];
        end
    end

    typedef struct {
        int           n;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [PW-1:0] r;
        int           done_cyc;
        int           writes;
    } vec_t;

    vec_t vecs [0:3];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Expected {busy, done, mac_en, r_we, arith_op, reg_op} at cycle t of a run,
    // from the row period P = N + L + 2.
    function automatic logic [5:0] exp_status(input int n, input int t, output logic [ADDR_W-1:0] wa);
        int   p, d, r, off;
        logic bz, dn, en, we, ar, dat;
        p = n + L + 2;
        d = (n == 0) ? 1 : n * p + 1;
        bz = (t >= 1) && (t <= d);
        dn = (t == d);
        en = bz && (n != 0);
        we = 1'b0; ar = 1'b0; dat = 1'b0; wa = '0;
        if (n != 0 && t >= 1 && t <= n * p) begin
            r   = (t - 1) / p;
            off = t - r * p;
            if (off >= L + 2 && off <= L + 1 + n) begin
                we = 1'b1; dat = 1'b1; ar = (off != L + 2);
                wa = ADDR_W'(r + off - L - 2);
            end else if (off == p) begin
                we = 1'b1;
                wa = ADDR_W'(r + n);
            end
        end
        return {bz, dn, en, we, ar, bz && !dat};
    endfunction

    // Load memories, run one multiply and check every cycle's control outputs.
    task automatic run_mul(input int n, input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input int pert_lo, input int pert_hi, input int rst_at,
                           output int done_at, output int nwr);
        int               d;
        logic [5:0]       st;
        logic [ADDR_W-1:0] wa;
        for (int k = 0; k < 32; k++) begin
            if (k < n && k < MAXN) begin
                mem_a[k] = a[k*W +: W];
                mem_b[k] = b[k*W +: W];
            end else begin
                mem_a[k] = rand72();
                mem_b[k] = rand72();
            end
            fill_r[k] = rand72();
        end
        @(negedge clock); fill_req = 1'b1;
        @(negedge clock); fill_req = 1'b0;
        done_at = -1;
        nwr     = 0;
        d = (n == 0) ? 1 : n * (n + L + 2) + 1;
        for (int t = 0; t <= d + 1; t++) begin
            @(negedge clock);
            start   = (t == 0) || (t >= pert_lo && t <= pert_hi);
            n_limbs = (t == 0) ? N_W'(n) : N_W'(n + 1);
            if (rst_at >= 0 && t == rst_at + 1) begin
                check("reset status", {66'd0, busy, done, mac_en, r_we, mac_arith_op, mac_reg_op}, 72'd0);
                check("reset addr", {52'd0, a_addr, b_addr, r_raddr, r_waddr}, 72'd0);
                check("reset wdata", r_wdata, 72'd0);
                check("reset mac ops", mac_a | mac_b | mac_c, 72'd0);
                nreset = 1'b1;
                break;
            end
            st = exp_status(n, t, wa);
            check($sformatf("status n=%0d t=%0d", n, t),
                  {66'd0, busy, done, mac_en, r_we, mac_arith_op, mac_reg_op}, {66'd0, st});
            if (st[2]) check($sformatf("waddr n=%0d t=%0d", n, t), {67'd0, r_waddr}, {67'd0, wa});
            if (r_we) nwr++;
            if (done && done_at < 0) done_at = t;
            if (t == rst_at) nreset = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string name, input int n, input logic [PW-1:0] prod,
                                input int done_exp, input int wr_exp,
                                input int done_at, input int nwr);
        check($sformatf("%s done cycle", name), W'(done_at), W'(done_exp));
        check($sformatf("%s write count", name), W'(nwr), W'(wr_exp));
        for (int k = 0; k < 2 * n; k++)
            check($sformatf("%s R[%0d]", name, k), mem_r[k], prod[k*W +: W]);
    endtask

    initial begin
        logic [W-1:0]  ones;
        logic [BW-1:0] a, b;
        logic [PW-1:0] prod;
        int            da, nw;

        ones     = '1;
        nreset   = 1'b0;
        start    = 1'b0;
        n_limbs  = '0;
        fill_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            mem_a[k] = '0; mem_b[k] = '0; fill_r[k] = '0;
        end

        vecs[0] = '{1, BW'(5), BW'(7), PW'(35), 10, 2};
        vecs[1] = '{2, BW'({ones, ones}), BW'({ones, ones}),
                    PW'({ones, ones - W'(1), W'(0), W'(1)}), 21, 6};
        vecs[2] = '{0, BW'(3), BW'(4), PW'(0), 1, 0};
        vecs[3] = '{1, BW'(ones), BW'(ones), PW'({ones - W'(1), W'(1)}), 10, 2};

        repeat (3) @(negedge clock);
        check("reset status", {66'd0, busy, done, mac_en, r_we, mac_arith_op, mac_reg_op}, 72'd0);
        check("reset addr", {52'd0, a_addr, b_addr, r_raddr, r_waddr}, 72'd0);
        check("reset wdata", r_wdata, 72'd0);
        check("reset mac ops", mac_a | mac_b | mac_c, 72'd0);
        nreset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_mul(vecs[i].n, vecs[i].a, vecs[i].b, -1, -1, -1, da, nw);
            check_result($sformatf("vec%0d", i), vecs[i].n, vecs[i].r,
                         vecs[i].done_cyc, vecs[i].writes, da, nw);
        end

        for (int s = 0; s < 200; s++) begin
            a = '0; b = '0;
            for (int k = 0; k < 3; k++) begin
                a[k*W +: W] = rand72();
                b[k*W +: W] = rand72();
            end
            prod = {{BW{1'b0}}, a} * {{BW{1'b0}}, b};
            run_mul(3, a, b, -1, -1, -1, da, nw);
            check_result($sformatf("rand%0d", s), 3, prod, 3 * 11 + 1, 12, da, nw);
        end

        // start pulsed during row 1 of an N=2 run must change nothing.
        a = '0; b = '0;
        a[2*W-1:0] = {rand72(), rand72()};
        b[2*W-1:0] = {rand72(), rand72()};
        prod = {{BW{1'b0}}, a} * {{BW{1'b0}}, b};
        run_mul(2, a, b, 12, 14, -1, da, nw);
        check_result("restart", 2, prod, 21, 6, da, nw);

        // Reset in the middle of row 0, then a clean run.
        run_mul(2, a, b, -1, -1, 5, da, nw);
        a[2*W-1:0] = {rand72(), rand72()};
        b[2*W-1:0] = {rand72(), rand72()};
        prod = {{BW{1'b0}}, a} * {{BW{1'b0}}, b};
        run_mul(2, a, b, -1, -1, -1, da, nw);
        check_result("after reset", 2, prod, 21, 6, da, nw);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
